fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO; next generation of the team's buffer block between packet source and sink stages. Generalises width and depth and stores every word, including all-zero data. Adds:
- programmable almost-full/almost-empty thresholds
- occupancy count output
- sticky, cause-coded overflow/underflow error
- defined simultaneous push/pop behaviour at full and at empty

Parameters:
DATA_WIDTH, 10, data word width in bits
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 8)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
push  in  1  write request
pop  in  1  read request
data_in  in  DATA_WIDTH  write data
thr_alto  in  ADDR_WIDTH+1  almost-full threshold
thr_bajo  in  ADDR_WIDTH+1  almost-empty threshold
error_clr  in  1  clears sticky error
data_out  out  DATA_WIDTH  read data
data_valid  out  1  data_out carries a freshly popped word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= thr_alto
almost_empty  out  1  count <= thr_bajo
count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
error  out  1  sticky error flag
err_cause  out  2  sticky cause bits: [0] overflow, [1] underflow

Behaviour:
- Interface: reset reset, synchronous, active-low; clock clk.
- Reset (reset==0 at a clk edge):
  - wr_ptr, rd_ptr, count, data_out, data_valid, error and err_cause all go to 0.
  - empty=1, almost_empty=1 if thr_bajo>=0, full=0.
  - RAM contents are not reset.
  - Reset mid-operation discards all stored words; no push or pop is accepted in a reset cycle.
- Acceptance rules:
  - pop_ok = pop && !empty
  - push_ok = push && (!full || pop_ok)
- count update: +1 on push_ok only; -1 on pop_ok only; unchanged on both or neither.
- Pointers: wrap modulo DEPTH. wr_ptr advances on push_ok; rd_ptr advances on pop_ok.
- Full + push + pop: both accepted, count stays DEPTH, no error.
- Empty + push + pop: push accepted, pop rejected and flagged as underflow, count becomes 1.
- Overflow: push && full && !pop. Word is dropped; error<=1 and err_cause[0]<=1.
- Underflow: pop && empty. data_out holds; error<=1 and err_cause[1]<=1.
- Errors are sticky. error_clr clears error and err_cause. If a new error event occurs in the same cycle, the set wins for that cause.
- Read latency (default mode): data_out registered 1 cycle. On a pop_ok edge, data_out <= mem[rd_ptr] and data_valid=1 for exactly the following cycle. Otherwise data_valid=0 and data_out holds.
- Status flags (full, empty, almost_*): combinational from registered count; thresholds sampled live. thr_alto=0 makes almost_full permanently 1 (legal).
- Zero-valued data words are stored and counted like any other word.

Optional Feature:
FIFO_FWFT_EN
- Defined: first-word-fall-through. data_out = mem[rd_ptr] asynchronously while !empty; data_valid = !empty; pop_ok acknowledges and advances to the next word in the same cycle. Empty + push + pop still rejects the pop.
- Undefined: registered 1-cycle read latency as in Behaviour.

Decomposition:
- Package fifo_pkg: DEPTH derivation function/localparam, ERR_OVF=0 and ERR_UDF=1 bit indices, count-width localparam.
- One sub-module, fifo_ram: DEPTH x DATA_WIDTH register array, synchronous write port, read port combinational; the registered output stage lives in the top.
- Pointer, count, flag and error logic stay in the top.

Test Plan:
- Reset then idle: count=0, empty=1, full=0, error=0, data_valid=0, data_out=0.
- Push 8 words 0x000..0x007, then pop 8: count 8 -> 0; data_out sequence 0x000..0x007 (0x000 stored); data_valid one cycle after each pop; full=1 after 8th push.
- Full, push=1 pop=0 with 0x3FF: word dropped, count stays 8, error=1, err_cause=01. Then error_clr=1: error=0, err_cause=00.
- Full, push=1 pop=1: count stays 8, no error. Empty, push=1 pop=1 with 0x155: count=1, err_cause=10, next pop returns 0x155.
- thr_alto=6, thr_bajo=2, push 1..8: almost_empty high for count 0..2, almost_full high for count 6..8; pointer wraps after 8 push/pop cycles without data corruption.
- Reset asserted with count=5 mid-stream: next cycle count=0, empty=1, a subsequent pop flags underflow. Rerun with FIFO_FWFT_EN: first pushed word visible on data_out, data_valid=1 the cycle after push.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the fifo_sync_param buffer block.
//   fifo_depth(aw) : number of entries addressed by an aw-bit pointer
//   cnt_width(aw)  : width of an occupancy counter that must hold 0..DEPTH
//   ERR_OVF/ERR_UDF: bit positions inside the sticky err_cause vector
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int ERR_OVF = 0;   // push refused because the FIFO was full
   localparam int ERR_UDF = 1;   // pop refused because the FIFO was empty
   localparam int ERR_W   = 2;

   localparam int DEF_ADDR_WIDTH = 3;

   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   // One extra bit so that "completely full" is distinct from "empty".
   function automatic int cnt_width(input int addr_width);
      return addr_width + 1;
   endfunction

   localparam int DEF_DEPTH     = fifo_depth(DEF_ADDR_WIDTH);
   localparam int DEF_CNT_WIDTH = cnt_width(DEF_ADDR_WIDTH);

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// DEPTH x DATA_WIDTH storage array for fifo_sync_param.
// Ports:
//   clk       : clock, write on rising edge
//   we_i      : write enable
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address (combinational read)
//   rd_data_o : contents of mem[rd_addr_i]
// -----------------------------------------------------------------------------
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // NOTE: the storage array deliberately has no reset; an entry is never read
   // before it has been written, and leaving it out keeps the array a plain
   // register file without a reset fan-out to every bit.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO between packet source and sink stages.
// Build option: define FIFO_FWFT_EN for first-word-fall-through output
// (head word presented combinationally while not empty); otherwise the
// output is registered with one cycle of read latency.
// Ports:
//   clk          : clock, all state updates on rising edge
//   reset        : synchronous, active-low reset
//   push / pop   : write / read requests
//   data_in      : write data
//   thr_alto     : almost-full threshold  (almost_full  = count >= thr_alto)
//   thr_bajo     : almost-empty threshold (almost_empty = count <= thr_bajo)
//   error_clr    : clears the sticky error flag and cause bits
//   data_out     : read data
//   data_valid   : data_out carries a popped (or, in FWFT, head) word
//   full / empty : count == DEPTH / count == 0
//   almost_full / almost_empty : threshold flags
//   count        : occupancy 0..DEPTH
//   error        : sticky error flag
//   err_cause    : sticky causes, [0] overflow, [1] underflow
// -----------------------------------------------------------------------------
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH:0]   thr_alto,
   input  logic [ADDR_WIDTH:0]   thr_bajo,
   input  logic                  error_clr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  error,
   output logic [ERR_W-1:0]      err_cause
);

   localparam int CW    = cnt_width(ADDR_WIDTH);
   localparam int DEPTH = fifo_depth(ADDR_WIDTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [ERR_W-1:0]      err_cause_q, err_cause_d;
   logic                  error_q, error_d;
   logic [DATA_WIDTH-1:0] rd_data;

   logic pop_ok;
   logic push_ok;
   logic overflow;
   logic underflow;

   // Status flags are decoded from the registered count; thresholds are live.
   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_C);
   assign almost_full  = (count_q >= thr_alto);
   assign almost_empty = (count_q <= thr_bajo);
   assign count        = count_q;
   assign error        = error_q;
   assign err_cause    = err_cause_q;

   // Nothing is accepted during a reset cycle. A push into a full FIFO is
   // accepted only when a pop frees a slot in the same cycle.
   assign pop_ok    = reset && pop && !empty;
   assign push_ok   = reset && push && (!full || pop_ok);
   assign overflow  = push && full && !pop;
   assign underflow = pop && empty;

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk       (clk),
      .we_i      (push_ok),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (data_in),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // a _d signal unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      err_cause_d = error_clr ? '0 : err_cause_q;

      // Pointers wrap for free because DEPTH is a power of two.
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A new event overrides a clear for its own cause bit.
      if (overflow)  err_cause_d[ERR_OVF] = 1'b1;
      if (underflow) err_cause_d[ERR_UDF] = 1'b1;
      error_d = |err_cause_d;
   end

   // NOTE: sequential state is assigned with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         err_cause_q <= '0;
         error_q     <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         err_cause_q <= err_cause_d;
         error_q     <= error_d;
      end
   end

`ifdef FIFO_FWFT_EN
   // Head word falls through; a pop in the same cycle moves to the next word.
   assign data_out   = empty ? '0 : rd_data;
   assign data_valid = !empty;
`else
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  data_valid_q, data_valid_d;

   // Output register captures the head word on an accepted pop and otherwise
   // holds; data_valid is a one-cycle strobe.
   always_comb begin
      data_out_d   = pop_ok ? rd_data : data_out_q;
      data_valid_d = pop_ok;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
      end else begin
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
// Self-checking bench for fifo_sync_param. A queue-based reference model is
// advanced with every stimulus cycle; popped words go into a scoreboard queue
// that an independent monitor drains whenever the DUT presents data.
// Honours FIFO_FWFT_EN to match the build under test.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

   localparam int DW    = 10;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          push;
   logic          pop;
   logic [DW-1:0] data_in;
   logic [AW:0]   thr_alto;
   logic [AW:0]   thr_bajo;
   logic          error_clr;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          error;
   logic [1:0]    err_cause;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] model_q [$];   // words held by the reference FIFO
   logic [DW-1:0] exp_q   [$];   // words the DUT still has to present
   logic [1:0]    m_err;

   fifo_sync_param #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .pop          (pop),
      .data_in      (data_in),
      .thr_alto     (thr_alto),
      .thr_bajo     (thr_bajo),
      .error_clr    (error_clr),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .error        (error),
      .err_cause    (err_cause)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_status();
      int sz;
      sz = model_q.size();
      check("count",        count,        sz);
      check("empty",        empty,        sz == 0);
      check("full",         full,         sz == DEPTH);
      check("almost_full",  almost_full,  sz >= int'(thr_alto));
      check("almost_empty", almost_empty, sz <= int'(thr_bajo));
      check("error",        error,        |m_err);
      check("err_cause",    err_cause,    m_err);
   endtask

   // Apply one clock of stimulus, advance the model, check state after the edge.
   task automatic cycle(input logic rst_n, input logic p, input logic q,
                        input logic [DW-1:0] d, input logic clr);
      int sz;
      bit m_empty, m_full, pop_ok, push_ok;
      reset = rst_n; push = p; pop = q; data_in = d; error_clr = clr;
      if (!rst_n) begin
         model_q.delete();
         m_err = 2'b00;
      end else begin
         sz      = model_q.size();
         m_empty = (sz == 0);
         m_full  = (sz == DEPTH);
         pop_ok  = q && !m_empty;
         push_ok = p && (!m_full || pop_ok);
         if (clr) m_err = 2'b00;
         if (p && m_full && !q) m_err[0] = 1'b1;
         if (q && m_empty)      m_err[1] = 1'b1;
         if (pop_ok)  exp_q.push_back(model_q.pop_front());
         if (push_ok) model_q.push_back(d);
      end
      @(posedge clk);
      #1;
      check_status();
   endtask

   function automatic logic [DW-1:0] rand_word();
      return ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
   endfunction

   // Monitor: samples on the falling edge, independent of the stimulus thread.
   initial begin
      forever begin
         @(negedge clk);
`ifdef FIFO_FWFT_EN
         if (reset === 1'b1 && pop === 1'b1 && data_valid === 1'b1) begin
`else
         if (data_valid === 1'b1) begin
`endif
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_data: got 0x%0h, expected no word at %0t", data_out, $time);
            end else begin
               check("data_out", data_out, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_err = 2'b00;
      reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0; error_clr = 1'b0;
      thr_alto = 4'd6; thr_bajo = 4'd2;

      // Reset then idle.
      cycle(0, 0, 0, '0, 0);
      cycle(0, 0, 0, '0, 0);
      check("rst_data_out",   data_out,   0);
      check("rst_data_valid", data_valid, 0);
      cycle(1, 0, 0, '0, 0);

      // Fill with 0..7 (zero included), then drain in order.
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1, 1, 0, DW'(i), 0);
`ifdef FIFO_FWFT_EN
         if (i == 0) begin
            check("fwft_head_valid", data_valid, 1);
            check("fwft_head_data",  data_out,   0);
         end
`endif
      end
      check("full_after_8", full, 1);
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, 1, '0, 0);
      cycle(1, 0, 0, '0, 0);

      // Overflow while full, then clear.
      for (int i = 0; i < DEPTH; i++) cycle(1, 1, 0, rand_word(), 0);
      cycle(1, 1, 0, 10'h3FF, 0);
      cycle(1, 0, 0, '0, 1);

      // Push and pop together at full: no error, count held.
      cycle(1, 1, 1, 10'h2AA, 0);
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, 1, '0, 0);

      // Push and pop together at empty: pop rejected as underflow.
      cycle(1, 1, 1, 10'h155, 0);
      cycle(1, 0, 1, '0, 0);
      cycle(1, 0, 0, '0, 1);

      // Pointer wrap with one word in flight.
      cycle(1, 1, 0, rand_word(), 0);
      for (int i = 0; i < 3 * DEPTH; i++) cycle(1, 1, 1, rand_word(), 0);
      cycle(1, 0, 1, '0, 0);

      // Reset mid-stream with 5 words stored, then pop into empty.
      for (int i = 0; i < 5; i++) cycle(1, 1, 0, rand_word(), 0);
      cycle(0, 1, 1, rand_word(), 0);
      cycle(1, 0, 1, '0, 0);
      cycle(1, 0, 0, '0, 1);

      // Randomised traffic with live thresholds, clears and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         if (n % 40 == 0) begin
            thr_alto = 4'($urandom_range(0, 9));
            thr_bajo = 4'($urandom_range(0, 9));
         end
         cycle(($urandom_range(0, 199) != 0),
               ($urandom_range(0, 99) < 55),
               ($urandom_range(0, 99) < 50),
               rand_word(),
               ($urandom_range(0, 29) == 0));
      end

      // Let the monitor catch up and confirm nothing was left unpresented.
      cycle(1, 0, 0, '0, 0);
      cycle(1, 0, 0, '0, 0);
      @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
